// File: rtl/hartslag_meter_if.sv
// rtl/hartslag_meter_if.sv - heart-rate result bus between the meter and stress detection
interface hartslag_meter_if;
    logic [7:0] hartData;
    logic       hartValid;
    logic       beatTick;
    logic       hartErr;

    modport master (output hartData, output hartValid, output beatTick, output hartErr);
    modport slave  (input  hartData, input  hartValid, input  beatTick, input  hartErr);
endinterface

// File: rtl/hartslag_meter.sv
// rtl/hartslag_meter.sv - heartbeat period meter, 60000/interval_ms bpm via restoring divider
module hartslag_meter #(
    parameter int CLK_DIV         = 50000,
    parameter int MIN_INTERVAL_MS = 250,
    parameter int TIMEOUT_MS      = 3000
) (
    input  logic             clk,
    input  logic             extReset,
    input  logic             hartslagIngang,
    hartslag_meter_if.master hartBus
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, MEAS, DIV} stateType;

    stateType    state;
    logic        syncA, syncB, syncPrev;
    logic [PRE_W-1:0] preCnt;
    logic [11:0] msCnt;
    logic [11:0] interval;
    logic [11:0] divRem;
    logic [15:0] divQuo;
    logic [4:0]  divCnt;
    logic [7:0]  dataReg;
    logic        validReg, beatReg, errReg;

    logic        rise, msTick, edgeOk, timedOut, accept, divGe;
    logic [12:0] elapsed, divTrial, divDiff;

    assign rise     = syncB & ~syncPrev;
    assign msTick   = (preCnt == PRE_W'(CLK_DIV - 1));
    // Count the tick landing on this very edge, so an edge N*CLK_DIV cycles
    // after the reference measures exactly N ms.
    assign elapsed  = {1'b0, msCnt} + {12'd0, msTick};
    assign edgeOk   = rise && (elapsed >= 13'(MIN_INTERVAL_MS));
    assign timedOut = (msCnt >= 12'(TIMEOUT_MS));
    assign accept   = ((state == IDLE) && rise) || ((state == MEAS) && edgeOk);

    // Partial remainder is always below 2*interval, so bit 12 of the
    // difference is exactly the borrow of the trial subtraction.
    assign divTrial = {divRem, divQuo[15]};
    assign divDiff  = divTrial - {1'b0, interval};
    assign divGe    = ~divDiff[12];

    always_ff @(posedge clk) begin
        if (extReset) begin
            state    <= IDLE;
            syncA    <= 1'b0;
            syncB    <= 1'b0;
            syncPrev <= 1'b0;
            preCnt   <= '0;
            msCnt    <= '0;
            interval <= '0;
            divRem   <= '0;
            divQuo   <= '0;
            divCnt   <= '0;
            dataReg  <= '0;
            validReg <= 1'b0;
            beatReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            syncA    <= hartslagIngang;
            syncB    <= syncA;
            syncPrev <= syncB;
            beatReg  <= 1'b0;
            validReg <= 1'b0;

            if (accept || msTick) begin
                preCnt <= '0;
            end else begin
                preCnt <= preCnt + 1'b1;
            end

            if (accept) begin
                msCnt <= '0;
            end else if (msTick && (state != IDLE)) begin
                msCnt <= msCnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        beatReg <= 1'b1;
                        state   <= MEAS;
                    end
                end
                MEAS: begin
                    if (edgeOk) begin
                        beatReg  <= 1'b1;
                        interval <= elapsed[12] ? 12'hFFF : elapsed[11:0];
                        divRem   <= '0;
                        divQuo   <= 16'd60000;
                        divCnt   <= '0;
                        state    <= DIV;
                    end else if (timedOut) begin
                        errReg  <= 1'b1;
                        dataReg <= '0;
                        state   <= IDLE;
                    end
                end
                DIV: begin
                    if (divCnt == 5'd16) begin
                        dataReg  <= (divQuo > 16'd255) ? 8'hFF : divQuo[7:0];
                        validReg <= 1'b1;
                        errReg   <= 1'b0;
                        state    <= MEAS;
                    end else begin
                        divRem <= divGe ? divDiff[11:0] : divTrial[11:0];
                        divQuo <= {divQuo[14:0], divGe};
                        divCnt <= divCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hartBus.hartData  = dataReg;
    assign hartBus.hartValid = validReg;
    assign hartBus.beatTick  = beatReg;
    assign hartBus.hartErr   = errReg;
endmodule

// File: tb/tb_hartslag_meter.sv
// tb/tb_hartslag_meter.sv - randomized beat trains checked against an event-level bpm model
module tb_hartslag_meter;
    localparam int CLK_DIV = 10;
    localparam int MIN_MS  = 250;
    localparam int TO_MS   = 3000;

    logic clk      = 1'b0;
    logic extReset = 1'b1;
    logic din      = 1'b0;

    hartslag_meter_if hartBus ();

    hartslag_meter #(
        .CLK_DIV(CLK_DIV),
        .MIN_INTERVAL_MS(MIN_MS),
        .TIMEOUT_MS(TO_MS)
    ) dut (
        .clk(clk),
        .extReset(extReset),
        .hartslagIngang(din),
        .hartBus(hartBus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: the raw input seen at the last three edges, the edge of
    // the last accepted beat, and the pending reading with its due edge.
    int       n = 0;
    bit       h1 = 0, h2 = 0, h3 = 0;
    bit       haveRef = 0, started = 0;
    int       aLast = 0, pendAt = -1, pendVal = 0;
    bit       cur, rst, riseSeen, accepted;
    int       elapsedMs;
    logic [7:0] expData = 8'd0;
    logic     expErr = 1'b0, expBeat = 1'b0, expValid = 1'b0;

    initial begin : compareProc
        forever begin
            @(posedge clk);
            cur = din;
            rst = extReset;
            #1;
            n++;
            if (rst) begin
                started = 1; haveRef = 0; pendAt = -1;
                h1 = 0; h2 = 0; h3 = 0;
                expData = 8'd0; expErr = 0; expBeat = 0; expValid = 0;
            end else begin
                riseSeen = h2 && !h3;
                h3 = h2; h2 = h1; h1 = cur;
                expBeat = 0; expValid = 0; accepted = 0;
                if (riseSeen) begin
                    if (!haveRef) begin
                        accepted = 1; haveRef = 1; aLast = n; expBeat = 1;
                    end else begin
                        elapsedMs = (n - aLast) / CLK_DIV;
                        if (elapsedMs >= MIN_MS) begin
                            accepted = 1; expBeat = 1; aLast = n;
                            pendAt  = n + 17;
                            pendVal = (60000 / elapsedMs > 255) ? 255 : 60000 / elapsedMs;
                        end
                    end
                end
                if (!accepted && haveRef && (n - aLast) == TO_MS * CLK_DIV + 1) begin
                    expErr = 1; expData = 8'd0; haveRef = 0;
                end
                if (n == pendAt) begin
                    expValid = 1; expData = 8'(pendVal); expErr = 0; pendAt = -1;
                end
            end
            if (started) begin
                vectors++;
                if (hartBus.hartData !== expData || hartBus.hartValid !== expValid ||
                    hartBus.beatTick !== expBeat || hartBus.hartErr !== expErr) begin
                    miscompares++;
                    $display("FAIL cycle %0d outputs: data=%0d valid=%b beat=%b err=%b, need data=%0d valid=%b beat=%b err=%b",
                             n, hartBus.hartData, hartBus.hartValid, hartBus.beatTick, hartBus.hartErr,
                             expData, expValid, expBeat, expErr);
                end
            end
        end
    end

    task automatic checkLit(input string name, input logic [15:0] actual, input int expected);
        vectors++;
        if (actual !== 16'(expected)) begin
            miscompares++;
            $display("FAIL %s: got %0d, need %0d", name, actual, expected);
        end
    endtask

    // Rising edge now, next rising edge `period` cycles later; optional
    // refractory glitch at offset `glitch`; reading checked 25 cycles in.
    task automatic beat(input int period, input int width, input int glitch,
                        input int expLit, input string tag);
        din = 1'b1;
        for (int i = 1; i <= period; i++) begin
            @(negedge clk);
            if (i == width) din = 1'b0;
            if (glitch > 0 && i == glitch) din = 1'b1;
            if (glitch > 0 && i == glitch + 2) din = 1'b0;
            if (i == 25 && expLit >= 0) checkLit(tag, 16'(hartBus.hartData), expLit);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkLit({tag, "Data"},  16'(hartBus.hartData),  0);
        checkLit({tag, "Valid"}, 16'(hartBus.hartValid), 0);
        checkLit({tag, "Beat"},  16'(hartBus.beatTick),  0);
        checkLit({tag, "Err"},   16'(hartBus.hartErr),   0);
    endtask

    initial begin : stimulus
        int p, w, g;
        repeat (3) @(negedge clk);
        extReset = 1'b0;
        checkZeros("reset");

        beat(10000, 3, 0, -1, "first");
        beat(30008, 3, 0, 60, "bpm60");
        checkLit("timeoutErr", 16'(hartBus.hartErr), 1);
        checkLit("timeoutData", 16'(hartBus.hartData), 0);
        beat(10000, 3, 0, -1, "rearm");
        checkLit("errHeld", 16'(hartBus.hartErr), 1);
        beat(7000, 3, 0, 60, "bpm60b");
        checkLit("errCleared", 16'(hartBus.hartErr), 0);
        beat(5000, 2, 0, 85, "bpm85");
        beat(2500, 2, 0, 120, "bpm120");
        beat(8000, 2, 1000, 240, "bpm240");
        beat(2600, 4, 0, 75, "bpm75");

        for (int k = 0; k < 3; k++) begin
            w = $urandom_range(6, 2);
            if (k == 2) begin
                p = $urandom_range(2700, 2600);
                g = 0;
            end else begin
                p = $urandom_range(2700, 2480);
                g = ($urandom_range(1, 0) == 1) ? $urandom_range(1500, 200) : 0;
            end
            beat(p, w, g, -1, "random");
        end

        din = 1'b1;
        repeat (2) @(negedge clk);
        din = 1'b0;
        repeat (8) @(negedge clk);
        extReset = 1'b1;
        @(negedge clk);
        extReset = 1'b0;
        checkZeros("midDivReset");

        beat(6000, 2, 0, -1, "afterReset");
        beat(30, 2, 0, 100, "bpm100");
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hartslag_meter.md
# hartslag_meter

Measures the period of the heartbeat-sensor pulse train and converts it to beats per minute for the stress-detection stage. It sits directly upstream of the stress module: its `hartData` bus and `hartValid` strobe feed the heart-rate input of stress detection. It also flags loss of the heartbeat signal. It synchronises the raw sensor input, rejects pulses inside a refractory window, and times intervals in millisecond ticks. A sequential divider then computes 60000 / interval.

## Interface

Parameters:

- `CLK_DIV`, 50000: clock cycles per 1 ms tick; must be ≥ 2.
- `MIN_INTERVAL_MS`, 250: refractory window in ms. Edges closer than this to the last accepted edge are ignored. Must be ≥ 236.
- `TIMEOUT_MS`, 3000: no accepted edge for this many ms counts as lost signal. Must be ≤ 4095 and > `MIN_INTERVAL_MS`.

Ports:

- `clk`, input, 1: system clock.
- `extReset`, input, 1: reset, synchronous, active-high.
- `hartslagIngang`, input, 1: raw heartbeat pulse, asynchronous to `clk`.
- `hartData`, output, 8: heart rate in bpm, floor(60000 / interval_ms).
- `hartValid`, output, 1: one-cycle strobe; `hartData` was updated this cycle.
- `beatTick`, output, 1: one-cycle strobe per accepted beat.
- `hartErr`, output, 1: level; heartbeat lost.

## Operation

Input conditioning:

- Two-flop synchroniser, then a registered previous value.
- `rise` = synced & ~previous.

Millisecond prescaler:

- Counts 0..`CLK_DIV`-1 and issues `msTick` on the terminal count.
- Cleared to 0 on every accepted edge.

Interval counter `msCnt`:

- 12 bits.
- Incremented on `msTick` in MEAS and DIV.
- Cleared on an accepted edge.

FSM states:

- IDLE (reset state; no reference beat yet)
  - `rise`: accept the edge, clear `msCnt` and the prescaler, pulse `beatTick`, go to MEAS.
  - No `hartData` update.
- MEAS
  - `rise` with `msCnt` ≥ `MIN_INTERVAL_MS`: accept the edge, latch `interval` = `msCnt`, clear `msCnt` and the prescaler, pulse `beatTick`, go to DIV.
  - `rise` with `msCnt` < `MIN_INTERVAL_MS`: ignored. No `beatTick`, no state change.
  - `msCnt` reaches `TIMEOUT_MS`: set `hartErr`, set `hartData` to 0, go to IDLE.
  - If `rise` and timeout occur in the same cycle, the edge wins.
- DIV
  - Restoring division of the 16-bit constant 60000 by the 12-bit `interval`, one quotient bit per cycle, MSB first.
  - Runs exactly 16 iterations, then one finalize cycle.
  - Finalize: `hartData` = quotient saturated at 255, pulse `hartValid`, clear `hartErr`, go to MEAS.
  - `rise` during DIV is ignored. This is a parameter-guaranteed non-event, since the refractory window far exceeds 17 cycles.

Arithmetic:

- Quotient is truncated (floor); no rounding.
- Remainder is discarded.

Reset (any state, including mid-division):

- Outputs: `hartData` = 0, `hartValid` = 0, `beatTick` = 0, `hartErr` = 0.
- State IDLE.
- All counters and synchroniser flops cleared.

## Timing

- `hartslagIngang` high at clock edge E0 → `beatTick` high in the cycle after edge E2 (3-edge latency), when the edge is accepted.
- `hartValid` and the new `hartData` value appear exactly 17 cycles after `beatTick` (16 divide cycles + 1 finalize). `hartData` is stable until the next finalize, timeout, or reset.
- The timeout fires on the `msTick` that makes `msCnt` = `TIMEOUT_MS`. `hartErr` and `hartData` = 0 are registered in the next cycle.
- All outputs are registered.
- Input pulses must stay high for ≥ 2 clock cycles. Shorter pulses may be missed.

## Test plan

All scenarios use `CLK_DIV` = 10, `MIN_INTERVAL_MS` = 250, `TIMEOUT_MS` = 3000.

- Steady beat, rising edges every 10000 cycles (1000 ms):
  - First edge → `beatTick` only.
  - Each later edge → `beatTick`, then 17 cycles later `hartValid` with `hartData` = 60.
  - `hartErr` stays 0.
- Edge period 7000 cycles (700 ms) → `hartData` = 85 (floor). Period 5000 cycles → `hartData` = 120. Period 2500 cycles → `hartData` = 240.
- Refractory: accepted beat, then an extra pulse 1000 cycles (100 ms) later, then a pulse at 8000 cycles:
  - No `beatTick` for the 100 ms pulse.
  - Pulse at 8000 cycles → `hartData` = 75.
- Timeout: after a valid 60 bpm reading, no input for 30000+ cycles → `hartErr` = 1 and `hartData` = 0 about 30001 cycles after the last accepted edge.
  - Next edge → `beatTick`, no `hartValid`.
  - The edge after it (1000 ms) → `hartValid`, `hartData` = 60, `hartErr` = 0.
- `extReset` asserted for one cycle mid-DIV → next cycle all outputs 0, state IDLE.
  - The following two edges 6000 cycles apart → `hartData` = 100.
